// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
//   NUM_LANES : number of output lanes
//   SEL_W     : width of the lane select
//   sel_t       : lane select type
//   lane_mask_t : one-hot lane mask / lane-valid vector
package demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/dec_2_to_4.sv
// Combinational 2-to-4 one-hot decoder with enable.
//   i_sel  : lane select
//   i_en   : enable; mask is all zero when low
//   o_mask : one-hot lane mask
module dec_2_to_4
  import demux_pkg::*;
(
  input  sel_t       i_sel,
  input  logic       i_en,
  output lane_mask_t o_mask
);

  always_comb begin
    o_mask = '0;
    if (i_en) o_mask[i_sel] = 1'b1;
  end

endmodule

// File: rtl/demux_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer. Steers in to lane[sel] one cycle later,
// zeroes every other lane and raises a one-hot lane strobe.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   sel       : lane select 0..3
//   in        : data word
//   in_valid  : qualifies in/sel this cycle
//   out       : 4 lanes, lane k at [k*DATA_W +: DATA_W]
//   out_valid : one-hot lane strobe
module demux_1_to_4_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEL_W-1:0]            sel,
  input  logic [DATA_W-1:0]           in,
  input  logic                        in_valid,
  output logic [NUM_LANES*DATA_W-1:0] out,
  output logic [NUM_LANES-1:0]        out_valid
);

  lane_mask_t                           w_mask;
  logic [NUM_LANES-1:0][DATA_W-1:0]     r_lane;
  lane_mask_t                           r_out_valid;

  dec_2_to_4 u_dec (
    .i_sel  (sel),
    .i_en   (in_valid),
    .o_mask (w_mask)
  );

  // Mask doubles as the gate for each lane and the next strobe value, so a
  // lane with a low strobe always reads zero and nothing is held over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_valid <= '0;
    else        r_out_valid <= w_mask;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_lane[k] <= '0;
      else if (w_mask[k]) r_lane[k] <= in;
      else                r_lane[k] <= '0;
    end
  end

  // Packed lane array flattens with lane k at [k*DATA_W +: DATA_W].
  assign out       = r_lane;
  assign out_valid = r_out_valid;

  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
                                in_valid |-> !$isunknown(sel))
    else $error("sel unknown while in_valid");

endmodule

// File: tb/tb_demux_1_to_4_reg.sv
module tb_demux_1_to_4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic [7:0] d8;
  logic       in_valid;
  logic [31:0] out8;
  logic [3:0]  vld8;
  logic [3:0]  out1;
  logic [3:0]  vld1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] o8;
    logic [3:0]  o1;
    logic [3:0]  v;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  demux_1_to_4_reg #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in(d8), .in_valid(in_valid),
    .out(out8), .out_valid(vld8)
  );

  demux_1_to_4_reg #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in(d8[0]), .in_valid(in_valid),
    .out(out1), .out_valid(vld1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Drive one cycle at negedge, push the reference result, compare after the edge.
  task automatic drive(input string tag, input logic v, input logic [1:0] s,
                       input logic [7:0] d);
    exp_t e;
    exp_t g;
    @(negedge clk);
    in_valid = v; sel = s; d8 = d;
    e.o8 = v ? (32'(d) << (32'(s) * 8)) : 32'h0;
    e.o1 = v ? (4'(d[0]) << s) : 4'h0;
    e.v  = v ? (4'b0001 << s) : 4'h0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_qempty"}, 1, 0);
    end else begin
      g = sb_q.pop_front();
      chk({tag, "_out8"}, 64'(out8), 64'(g.o8));
      chk({tag, "_vld8"}, 64'(vld8), 64'(g.v));
      chk({tag, "_out1"}, 64'(out1), 64'(g.o1));
      chk({tag, "_vld1"}, 64'(vld1), 64'(g.v));
      chk({tag, "_onehot"}, 64'($countones(vld8) <= 1), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; d8 = 8'h00;
    #3;
    chk("rst_out8", 64'(out8), 0);
    chk("rst_vld8", 64'(vld8), 0);
    chk("rst_out1", 64'(out1), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Lane sweep with single-bit data.
    for (int s = 0; s < 4; s++) drive("sweep", 1'b1, 2'(s), 8'h01);
    // Wide data into lane 2.
    drive("wide", 1'b1, 2'd2, 8'hA5);
    // Invalid cycle clears the previous lane.
    drive("idle", 1'b0, 2'd3, 8'h01);
    // Zero data still strobes.
    drive("zero", 1'b1, 2'd1, 8'h00);
    // Back-to-back with changing sel and data.
    drive("b2b0", 1'b1, 2'd3, 8'hFF);
    drive("b2b1", 1'b1, 2'd0, 8'h3C);

    // Mid-cycle async reset with valid input pending.
    @(negedge clk);
    in_valid = 1'b1; sel = 2'd3; d8 = 8'h01;
    @(posedge clk); #2;
    in_valid = 1'b1; sel = 2'd2; d8 = 8'h01;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out8", 64'(out8), 0);
    chk("arst_vld8", 64'(vld8), 0);
    chk("arst_out1", 64'(out1), 0);
    chk("arst_vld1", 64'(vld1), 0);
    @(posedge clk); #1;
    chk("arst_hold_vld8", 64'(vld8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    // First capture after release.
    drive("post_rst", 1'b1, 2'd1, 8'h5A);

    // Random traffic.
    for (int i = 0; i < 1000; i++)
      drive("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)));

    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_1_to_4_reg.md
Name: demux_1_to_4_reg

Overview:
Registered 1-to-4 demultiplexer. Steers a single input word to one of four output lanes, selected by a 2-bit select. All non-selected lanes are driven to zero. Used wherever one source fans out to four consumers, with one-hot lane-valid strobes for downstream qualification.

Parameters:
DATA_W, 1, width of the input word and of each output lane (legal range 1..64)

Ports:
clk  input  1  rising-edge clock for all state
rst_n  input  1  asynchronous active-low reset
sel  input  2  lane select, 0..3
in  input  DATA_W  data word to steer
in_valid  input  1  qualifies in/sel for the current cycle
out  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
out_valid  output  4  one-hot lane strobe; bit k high means lane k holds fresh data

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: while rst_n=0, out=0 and out_valid=0 immediately, independent of clk. After release, the first capture occurs on the first rising clk edge with rst_n=1.
- Latency is exactly 1 cycle. At each rising edge with in_valid=1:
  - lane[sel] <= in.
  - all other lanes <= 0.
  - out_valid <= 4'b0001 << sel.
- At each rising edge with in_valid=0:
  - out <= 0.
  - out_valid <= 0.
  - No data is held over between cycles.
- Invariant: at every cycle, out_valid has at most one bit set. Any lane whose out_valid bit is 0 reads all zeros.
- sel is exactly 2 bits, so there is no out-of-range case. All four codes are legal.
- X on sel while in_valid=1 is a bench error. The design is not required to resolve it. An SVA assertion flags it in simulation only.
- Reset asserted mid-stream: outputs clear asynchronously. The in-flight word is discarded, not replayed.
- Back-to-back valid cycles with changing sel are supported every cycle. There is no handshake or backpressure, and no ready signal.
- The combinational select decode lives in a pure-logic sub-module. The output register stage sits in the top.
- Width rules: in is placed unmodified in its lane, with no sign or zero extension beyond DATA_W.

Decomposition:
- Shared package demux_pkg holds:
  - constants NUM_LANES=4 and SEL_W=2.
  - typedef sel_t as logic [SEL_W-1:0].
  - typedef lane_mask_t as logic [NUM_LANES-1:0].
- Sub-module dec_2_to_4 is combinational:
  - inputs: sel, en.
  - output: one-hot lane_mask_t, all zero when en=0.
  - The top uses the mask both to gate data per lane and as the next value of out_valid.

Test Plan:
- Reset check: drive rst_n=0 mid-cycle with in_valid=1 and in=1 → out=0 and out_valid=0 immediately, before the next clk edge.
- Sweep with DATA_W=1: in=1, in_valid=1, sel=0,1,2,3 on consecutive cycles → one cycle later out reads 0001, 0010, 0100, 1000 in turn, with out_valid equal to out each cycle.
- Wide data with DATA_W=8: in=8'hA5, sel=2 → lane2=8'hA5 and lanes 0, 1, 3 = 8'h00; out_valid=4'b0100.
- Invalid cycle: in_valid=0 with in=1, sel=3 → on the next edge out=0 and out_valid=0. The previous lane value is cleared, not held.
- Zero data: in=0, sel=1, in_valid=1 → out=0 and out_valid=4'b0010. The strobe distinguishes this from the idle case.
- Random: 1000 cycles of random in/sel/in_valid, checked against a 1-cycle-delayed reference model → at most one bit of out_valid set every cycle, and no mismatches.
